// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller drives strobes/selects from the master side; the datapath feeds back op/funct/flags.
interface mips_multicycle_ctrl_if;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        PCWrite;
    logic        IRWrite;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        IorD;
    logic        RegDst;
    logic        MemtoReg;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  PCSrc;
    logic [3:0]  ALUControl;
    logic [3:0]  state;
    logic        trap;
    logic [31:0] retired;

    modport master (
        input  op, funct, zero, mem_ready,
        output PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
        output IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
        output state, trap, retired
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite,
        input  IorD, RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSrc, ALUControl,
        input  state, trap, retired
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore decode of the state register, with memory-ready
// gated strobes, a sticky illegal-instruction trap and a retired-instruction counter.
module mips_multicycle_ctrl (
    input  logic                   CLK,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_e      state_q, state_d;
    logic        trap_q, trap_d;
    logic [31:0] retired_q, retired_d;

    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        iord, reg_dst, memto_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_ctrl;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            trap_q    <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            trap_q    <= trap_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXEC;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (bus.op == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC: begin
                case (bus.funct)
                    6'b100000, 6'b100010, 6'b100100,
                    6'b100101, 6'b101010: state_d = S_ALUWB;
                    default:              state_d = S_TRAP;
                endcase
            end
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_TRAP;
        endcase
    end

    // Any entry into FETCH from another state is a completed instruction; TRAP never leaves.
    always_comb begin
        trap_d    = trap_q | (state_d == S_TRAP);
        retired_d = retired_q;
        if (state_d == S_FETCH && state_q != S_FETCH)
            retired_d = retired_q + 32'd1;
    end

    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        iord      = 1'b0;
        reg_dst   = 1'b0;
        memto_reg = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        pc_src    = 2'b00;
        alu_ctrl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memto_reg = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = bus.mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (bus.funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = 2'b01;
                pc_write  = bus.zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides the decode combinationally so strobes drop without waiting for a clock.
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            iord      = 1'b0;
            reg_dst   = 1'b0;
            memto_reg = 1'b0;
            alu_src_a = 1'b0;
            alu_src_b = 2'b01;
            pc_src    = 2'b00;
            alu_ctrl  = ALU_ADD;
        end
    end

    assign bus.PCWrite    = pc_write;
    assign bus.IRWrite    = ir_write;
    assign bus.MemRead    = mem_read;
    assign bus.MemWrite   = mem_write;
    assign bus.RegWrite   = reg_write;
    assign bus.IorD       = iord;
    assign bus.RegDst     = reg_dst;
    assign bus.MemtoReg   = memto_reg;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.PCSrc      = pc_src;
    assign bus.ALUControl = alu_ctrl;
    assign bus.state      = state_q;
    assign bus.trap       = trap_q;
    assign bus.retired    = retired_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for the multicycle MIPS controller: directed per-cycle vectors queue their
// expected outputs; a negedge monitor pops and compares them against the DUT.
module tb_mips_multicycle_ctrl;
    logic CLK;
    logic reset;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [3:0] F = 4'd0, D = 4'd1, MA = 4'd2, MR = 4'd3, MWB = 4'd4, MWR = 4'd5;
    localparam logic [3:0] EX = 4'd6, AWB = 4'd7, BR = 4'd8, AEX = 4'd9, AIW = 4'd10;
    localparam logic [3:0] JMP = 4'd11, TRP = 4'd12;
    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR = 6'b100101, FN_SLT = 6'b101010, FN_BAD = 6'b000000;

    typedef struct {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] ret;
        logic        trap;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 32'd0;
    logic        exp_trap = 1'b0;

    // Control word layout: {PCWrite,IRWrite,MemRead,MemWrite,RegWrite,IorD,RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSrc,ALUControl}
    function automatic logic [16:0] ctrl_for(input logic [3:0] st, input logic [5:0] fn,
                                             input logic z, input logic mr, input logic in_rst);
        logic [3:0] alu;
        case (fn)
            FN_SUB:  alu = 4'b0110;
            FN_AND:  alu = 4'b0000;
            FN_OR:   alu = 4'b0001;
            FN_SLT:  alu = 4'b0111;
            default: alu = 4'b0010;
        endcase
        if (in_rst) return {9'b000000000, 2'b01, 2'b00, 4'b0010};
        case (st)
            F:       return {mr, mr, 7'b1000000, 2'b01, 2'b00, 4'b0010};
            D:       return {9'b000000000, 2'b11, 2'b00, 4'b0010};
            MA:      return {9'b000000001, 2'b10, 2'b00, 4'b0010};
            MR:      return {9'b001001000, 2'b00, 2'b00, 4'b0010};
            MWB:     return {9'b000010010, 2'b00, 2'b00, 4'b0010};
            MWR:     return {3'b000, mr, 5'b01000, 2'b00, 2'b00, 4'b0010};
            EX:      return {9'b000000001, 2'b00, 2'b00, alu};
            AWB:     return {9'b000010100, 2'b00, 2'b00, 4'b0010};
            BR:      return {z, 8'b00000001, 2'b00, 2'b01, 4'b0110};
            AEX:     return {9'b000000001, 2'b10, 2'b00, 4'b0010};
            AIW:     return {9'b000010000, 2'b00, 2'b00, 4'b0010};
            JMP:     return {9'b100000000, 2'b00, 2'b10, 4'b0010};
            default: return {9'b000000000, 2'b00, 2'b00, 4'b0010};
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs just after the edge, queue what this cycle must show.
    task automatic cyc(input logic [3:0] st, input logic [5:0] o, input logic [5:0] fn,
                       input logic z, input logic mr, input bit ret);
        exp_t e;
        bus.op        = o;
        bus.funct     = fn;
        bus.zero      = z;
        bus.mem_ready = mr;
        if (ret) exp_ret = exp_ret + 32'd1;
        e.st   = st;
        e.ctrl = ctrl_for(st, fn, z, mr, 1'b0);
        e.ret  = exp_ret;
        e.trap = exp_trap;
        sb.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic rst_cycles(input int n);
        exp_t e;
        reset    = 1'b0;
        exp_ret  = 32'd0;
        exp_trap = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.st   = F;
            e.ctrl = ctrl_for(F, 6'd0, 1'b0, bus.mem_ready, 1'b1);
            e.ret  = 32'd0;
            e.trap = 1'b0;
            sb.push_back(e);
            @(posedge CLK);
            #1;
        end
        reset = 1'b1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("state", {28'd0, bus.state}, {28'd0, e.st});
            chk("ctrl", {15'd0, bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite,
                         bus.IorD, bus.RegDst, bus.MemtoReg, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc,
                         bus.ALUControl}, {15'd0, e.ctrl});
            chk("retired", bus.retired, e.ret);
            chk("trap", {31'd0, bus.trap}, {31'd0, e.trap});
        end
    end

    initial begin
        reset         = 1'b0;
        bus.op        = 6'd0;
        bus.funct     = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge CLK);
        #1;
        rst_cycles(2);

        // lw, no wait states: 5 cycles
        cyc(F, OP_LW, 0, 0, 1, 0); cyc(D, OP_LW, 0, 0, 1, 0); cyc(MA, OP_LW, 0, 0, 1, 0);
        cyc(MR, OP_LW, 0, 0, 1, 0); cyc(MWB, OP_LW, 0, 0, 1, 0);
        // sw with three wait cycles in MEMWR: 7 cycles
        cyc(F, OP_SW, 0, 0, 1, 1); cyc(D, OP_SW, 0, 0, 1, 0); cyc(MA, OP_SW, 0, 0, 1, 0);
        cyc(MWR, OP_SW, 0, 0, 0, 0); cyc(MWR, OP_SW, 0, 0, 0, 0); cyc(MWR, OP_SW, 0, 0, 0, 0);
        cyc(MWR, OP_SW, 0, 0, 1, 0);
        // R-type sub, and, or, slt, add
        cyc(F, OP_R, FN_SUB, 0, 1, 1); cyc(D, OP_R, FN_SUB, 0, 1, 0);
        cyc(EX, OP_R, FN_SUB, 0, 1, 0); cyc(AWB, OP_R, FN_SUB, 0, 1, 0);
        cyc(F, OP_R, FN_AND, 0, 1, 1); cyc(D, OP_R, FN_AND, 0, 1, 0);
        cyc(EX, OP_R, FN_AND, 0, 1, 0); cyc(AWB, OP_R, FN_AND, 0, 1, 0);
        cyc(F, OP_R, FN_OR, 0, 1, 1); cyc(D, OP_R, FN_OR, 0, 1, 0);
        cyc(EX, OP_R, FN_OR, 0, 1, 0); cyc(AWB, OP_R, FN_OR, 0, 1, 0);
        cyc(F, OP_R, FN_SLT, 0, 1, 1); cyc(D, OP_R, FN_SLT, 0, 1, 0);
        cyc(EX, OP_R, FN_SLT, 0, 1, 0); cyc(AWB, OP_R, FN_SLT, 0, 1, 0);
        cyc(F, OP_R, FN_ADD, 0, 1, 1); cyc(D, OP_R, FN_ADD, 0, 1, 0);
        cyc(EX, OP_R, FN_ADD, 0, 1, 0); cyc(AWB, OP_R, FN_ADD, 0, 1, 0);
        // beq taken, then not taken
        cyc(F, OP_BEQ, 0, 1, 1, 1); cyc(D, OP_BEQ, 0, 1, 1, 0); cyc(BR, OP_BEQ, 0, 1, 1, 0);
        cyc(F, OP_BEQ, 0, 0, 1, 1); cyc(D, OP_BEQ, 0, 0, 1, 0); cyc(BR, OP_BEQ, 0, 0, 1, 0);
        // addi
        cyc(F, OP_ADDI, 0, 0, 1, 1); cyc(D, OP_ADDI, 0, 0, 1, 0);
        cyc(AEX, OP_ADDI, 0, 0, 1, 0); cyc(AIW, OP_ADDI, 0, 0, 1, 0);
        // lw with one wait in FETCH and one in MEMRD
        cyc(F, OP_LW, 0, 0, 0, 1); cyc(F, OP_LW, 0, 0, 1, 0); cyc(D, OP_LW, 0, 0, 1, 0);
        cyc(MA, OP_LW, 0, 0, 1, 0); cyc(MR, OP_LW, 0, 0, 0, 0); cyc(MR, OP_LW, 0, 0, 1, 0);
        cyc(MWB, OP_LW, 0, 0, 1, 0);
        // abort a lw while it waits in MEMRD
        cyc(F, OP_LW, 0, 0, 1, 1); cyc(D, OP_LW, 0, 0, 1, 0); cyc(MA, OP_LW, 0, 0, 1, 0);
        cyc(MR, OP_LW, 0, 0, 0, 0);
        rst_cycles(2);
        // j after reset, retired restarts from 0
        cyc(F, OP_J, 0, 0, 1, 0); cyc(D, OP_J, 0, 0, 1, 0); cyc(JMP, OP_J, 0, 0, 1, 0);
        // R-type with unknown funct traps
        cyc(F, OP_R, FN_BAD, 0, 1, 1); cyc(D, OP_R, FN_BAD, 0, 1, 0);
        cyc(EX, OP_R, FN_BAD, 0, 1, 0);
        exp_trap = 1'b1;
        for (int i = 0; i < 3; i++) cyc(TRP, OP_R, FN_BAD, 0, 1, 0);
        rst_cycles(1);
        // illegal opcode traps and stays for 10 cycles
        cyc(F, OP_BAD, 0, 0, 1, 0); cyc(D, OP_BAD, 0, 0, 1, 0);
        exp_trap = 1'b1;
        for (int i = 0; i < 10; i++) cyc(TRP, OP_BAD, 0, 1, 1, 0);
        rst_cycles(1);
        // counter wrap: preload all-ones while FETCH waits, then complete a j
        force dut.retired_q = 32'hFFFF_FFFF;
        exp_ret = 32'hFFFF_FFFF;
        cyc(F, OP_J, 0, 0, 0, 0);
        release dut.retired_q;
        cyc(F, OP_J, 0, 0, 0, 0); cyc(F, OP_J, 0, 0, 1, 0); cyc(D, OP_J, 0, 0, 1, 0);
        cyc(JMP, OP_J, 0, 0, 1, 0);
        cyc(F, OP_J, 0, 0, 0, 1);
        cyc(F, OP_J, 0, 0, 0, 0);

        #10;
        chk("drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- CLK  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  instruction[31:26] from the instruction register.
- funct  in  6  instruction[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, IRWrite, MemRead, MemWrite, RegWrite  out  1 each  write/access strobes.
- IorD, RegDst, MemtoReg, ALUSrcA  out  1 each  datapath mux selects.
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2.
- PCSrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- ALUControl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- state  out  4  current FSM state code.
- trap  out  1  sticky illegal-instruction flag.
- retired  out  32  count of completed instructions.

Function
REQ-002 Outputs SHALL be Moore decodes of the registered state; the only exceptions are PCWrite/IRWrite/MemWrite gating by mem_ready and BRANCH PCWrite = zero.
REQ-003 State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11, TRAP 12; unused codes 13-15 SHALL go to TRAP.
REQ-004 Unlisted outputs default to 0 in every state; ALUControl defaults to 0010.
REQ-005 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, PCSrc=00, add; IRWrite=PCWrite=mem_ready; stays until mem_ready=1, then DECODE.
REQ-006 DECODE: ALUSrcA=0, ALUSrcB=11, add; next by op: 100011/101011 MEMADR, 000000 EXEC, 000100 BRANCH, 001000 ADDIEX, 000010 JUMP, any other TRAP.
REQ-007 MEMADR: ALUSrcA=1, ALUSrcB=10, add; next MEMRD if op=100011, else MEMWR.
REQ-008 MEMRD: MemRead=1, IorD=1; holds until mem_ready=1, then MEMWB.
REQ-009 MEMWB: RegWrite=1, RegDst=0, MemtoReg=1; next FETCH.
REQ-010 MEMWR: IorD=1, MemWrite=mem_ready; holds until mem_ready=1, then FETCH.
REQ-011 EXEC: ALUSrcA=1, ALUSrcB=00; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, then ALUWB; any other funct goes to TRAP.
REQ-012 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-013 BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, PCWrite=zero; next FETCH.
REQ-014 ADDIEX: ALUSrcA=1, ALUSrcB=10, add; next ADDIWB. ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-015 JUMP: PCSrc=10, PCWrite=1; next FETCH.
REQ-016 TRAP: all strobes 0, trap=1; remains in TRAP until reset.
REQ-017 Latency with mem_ready held at 1: lw 5 cycles; sw, R-type and addi 4; beq and j 3. Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds exactly one cycle.
REQ-018 retired SHALL increment by 1 on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP; it wraps FFFFFFFF->0 and never counts a trap.

Reset
REQ-019 reset=0 SHALL immediately, regardless of CLK, force state=FETCH, retired=0 and trap=0, and force all strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) to 0.
REQ-020 While reset=0, mux selects SHALL equal FETCH values and ALUControl=0010.
REQ-021 Asserting reset mid-instruction (including while waiting on mem_ready or in TRAP) SHALL abort that instruction without a count; the first edge after release begins FETCH.

Verification
REQ-022 Release reset, mem_ready=1, op=100011 -> states 0,1,2,3,4,0; RegWrite=1 only in cycle 5 with MemtoReg=1; retired=1.
REQ-023 op=101011, mem_ready low 3 cycles in MEMWR -> MemWrite=0 for 3 cycles, then 1 for one cycle; total 7 cycles; retired+1.
REQ-024 op=000000, funct=100010 -> ALUControl=0110 in EXEC; RegDst=1 and RegWrite=1 in ALUWB.
REQ-025 op=000100 with zero=1 -> PCWrite=1 and PCSrc=01 in BRANCH; with zero=0 -> PCWrite=0; both 3 cycles.
REQ-026 op=111111 -> TRAP (state=12), trap=1, retired unchanged over 10 cycles; reset pulse -> state=0, trap=0.
REQ-027 Force retired=FFFFFFFF, then complete a j -> retired=00000000.
